// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: default address map,
// region and FSM encodings, and the address decoder.
package mem_bus_arbiter_pkg;

   localparam int unsigned RamDepthDef = 2048;
   localparam int unsigned LedAddrDef  = 2048;
   localparam int unsigned BtnAddrDef  = 2049;

   typedef enum logic [1:0] {
      RegRam,
      RegLed,
      RegBtn,
      RegNone
   } region_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } state_e;

   // Map a zero-extended requester address onto the region it targets.
   function automatic region_e decode_region(input logic [31:0] addr,
                                             input int unsigned ram_depth,
                                             input int unsigned led_addr,
                                             input int unsigned btn_addr);
      if (addr < ram_depth) begin
         return RegRam;
      end else if (addr == led_addr) begin
         return RegLed;
      end else if (addr == btn_addr) begin
         return RegBtn;
      end
      return RegNone;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin grant selection. Purely combinational; the caller
// holds last_gnt in a register and updates it on each accepted grant.
module rr_arbiter2 (
   input  logic REQ0,
   input  logic REQ1,
   input  logic last_gnt,
   output logic gnt_valid,
   output logic gnt_id
);

   // On a tie the port that was not granted last time wins.
   always_comb begin
      gnt_valid = REQ0 | REQ1;
      gnt_id    = (REQ0 & REQ1) ? ~last_gnt : REQ1;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Sequences CPU and loader accesses to the shared single-port RAM and the
// LED/button I/O registers, one transaction at a time.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned RAM_DEPTH = RamDepthDef,
   parameter int unsigned LED_ADDR  = LedAddrDef,
   parameter int unsigned BTN_ADDR  = BtnAddrDef,
   parameter int unsigned LED_W     = 2
) (
   input  logic              CLK_100MHz,
   input  logic              RESET,
   input  logic              REQ0,
   input  logic              WE0,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [15:0]       WDATA0,
   output logic              ACK0,
   output logic [15:0]       RDATA0,
   input  logic              REQ1,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [15:0]       WDATA1,
   output logic              ACK1,
   output logic [15:0]       RDATA1,
   output logic [10:0]       RAM_ADDR,
   output logic              RAM_WE,
   output logic [15:0]       RAM_WDATA,
   input  logic [15:0]       RAM_RDATA,
   output logic [LED_W-1:0]  LED,
   input  logic              BUTTON
);

   state_e             state_q, state_d;
   region_e            region_q, region_d;
   logic               id_q, id_d;
   logic               we_q, we_d;
   logic [LED_W-1:0]   led_wdata_q, led_wdata_d;
   logic               last_gnt_q, last_gnt_d;
   logic               ack0_q, ack0_d;
   logic               ack1_q, ack1_d;
   logic [15:0]        rdata0_q, rdata0_d;
   logic [15:0]        rdata1_q, rdata1_d;
   logic [10:0]        ram_addr_q, ram_addr_d;
   logic               ram_we_q, ram_we_d;
   logic [15:0]        ram_wdata_q, ram_wdata_d;
   logic [LED_W-1:0]   led_q, led_d;
   logic               btn_meta_q, btn_sync_q;

   logic               gnt_valid;
   logic               gnt_id;
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [15:0]        sel_wdata;
   region_e            sel_region;
   logic               cap_en;
   logic [15:0]        cap_val;

   rr_arbiter2 u_rr_arbiter2 (
      .REQ0      (REQ0),
      .REQ1      (REQ1),
      .last_gnt  (last_gnt_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   // Mux the granted port's request and decode its target region.
   always_comb begin
      sel_we     = gnt_id ? WE1    : WE0;
      sel_addr   = gnt_id ? ADDR1  : ADDR0;
      sel_wdata  = gnt_id ? WDATA1 : WDATA0;
      sel_region = decode_region(32'(sel_addr), RAM_DEPTH, LED_ADDR, BTN_ADDR);
   end

   // Transaction FSM: next state, RAM command, I/O side effects and read capture.
   always_comb begin
      state_d     = state_q;
      region_d    = region_q;
      id_d        = id_q;
      we_d        = we_q;
      led_wdata_d = led_wdata_q;
      last_gnt_d  = last_gnt_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      led_d       = led_q;
      cap_en      = 1'b0;
      cap_val     = '0;

      unique case (state_q)
         StIdle: begin
            if (gnt_valid) begin
               id_d        = gnt_id;
               we_d        = sel_we;
               region_d    = sel_region;
               led_wdata_d = sel_wdata[LED_W-1:0];
               last_gnt_d  = gnt_id;
               state_d     = StIssue;
               // RAM command is registered here so it is stable for all of ISSUE.
               if (sel_region == RegRam) begin
                  ram_addr_d  = sel_addr[10:0];
                  ram_we_d    = sel_we;
                  ram_wdata_d = sel_wdata;
               end
            end
         end
         StIssue: begin
            state_d = StDone;
            unique case (region_q)
               RegRam: begin
                  if (!we_q) state_d = StWait;
               end
               RegLed: begin
                  if (we_q) begin
                     led_d = led_wdata_q;
                  end else begin
                     cap_en  = 1'b1;
                     cap_val = 16'(led_q);
                  end
               end
               RegBtn: begin
                  if (!we_q) begin
                     cap_en  = 1'b1;
                     cap_val = {15'b0, btn_sync_q};
                  end
               end
               RegNone: begin
                  if (!we_q) begin
                     cap_en  = 1'b1;
                     cap_val = '0;
                  end
               end
               default: ;
            endcase
         end
         StWait: begin
            cap_en  = 1'b1;
            cap_val = RAM_RDATA;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // ACK is registered so it is high exactly while in DONE.
      if (state_d == StDone && state_q != StDone) begin
         ack0_d = ~id_q;
         ack1_d = id_q;
      end

      if (cap_en) begin
         if (id_q) rdata1_d = cap_val;
         else      rdata0_d = cap_val;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK_100MHz) begin
      if (RESET) begin
         state_q     <= StIdle;
         region_q    <= RegNone;
         id_q        <= 1'b0;
         we_q        <= 1'b0;
         led_wdata_q <= '0;
         last_gnt_q  <= 1'b1;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         led_q       <= '0;
      end else begin
         state_q     <= state_d;
         region_q    <= region_d;
         id_q        <= id_d;
         we_q        <= we_d;
         led_wdata_q <= led_wdata_d;
         last_gnt_q  <= last_gnt_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         led_q       <= led_d;
      end
   end

   // Two-flop synchronizer for the asynchronous push-button.
   always_ff @(posedge CLK_100MHz) begin
      if (RESET) begin
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
      end else begin
         btn_meta_q <= BUTTON;
         btn_sync_q <= btn_meta_q;
      end
   end

   // Drive outputs straight from registers.
   always_comb begin
      ACK0      = ack0_q;
      ACK1      = ack1_q;
      RDATA0    = rdata0_q;
      RDATA1    = rdata1_q;
      RAM_ADDR  = ram_addr_q;
      RAM_WE    = ram_we_q;
      RAM_WDATA = ram_wdata_q;
      LED       = led_q;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a behavioural RAM plus a
// transaction-level reference model (shadow memory, LED value, per-port read data).
module tb_mem_bus_arbiter;

   logic        clk;
   logic        RESET;
   logic        REQ0, WE0, REQ1, WE1;
   logic [15:0] ADDR0, WDATA0, ADDR1, WDATA1;
   logic        ACK0, ACK1;
   logic [15:0] RDATA0, RDATA1;
   logic [10:0] RAM_ADDR;
   logic        RAM_WE;
   logic [15:0] RAM_WDATA;
   logic [15:0] RAM_RDATA;
   logic [1:0]  LED;
   logic        BUTTON;

   int unsigned n_pass;
   int unsigned n_total;

   // Reference model state.
   logic [15:0] shadow [2048];
   logic [1:0]  exp_led;
   logic [15:0] exp_rdata [2];

   // Single-port RAM with registered read.
   logic [15:0] ram_mem [2048];

   mem_bus_arbiter dut (
      .CLK_100MHz (clk),
      .RESET      (RESET),
      .REQ0       (REQ0),
      .WE0        (WE0),
      .ADDR0      (ADDR0),
      .WDATA0     (WDATA0),
      .ACK0       (ACK0),
      .RDATA0     (RDATA0),
      .REQ1       (REQ1),
      .WE1        (WE1),
      .ADDR1      (ADDR1),
      .WDATA1     (WDATA1),
      .ACK1       (ACK1),
      .RDATA1     (RDATA1),
      .RAM_ADDR   (RAM_ADDR),
      .RAM_WE     (RAM_WE),
      .RAM_WDATA  (RAM_WDATA),
      .RAM_RDATA  (RAM_RDATA),
      .LED        (LED),
      .BUTTON     (BUTTON)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (RAM_WE) ram_mem[RAM_ADDR] <= RAM_WDATA;
      RAM_RDATA <= ram_mem[RAM_ADDR];
   end

   function automatic logic [15:0] model_read(input logic [15:0] a);
      if (a < 16'd2048) return shadow[a[10:0]];
      if (a == 16'd2048) return {14'b0, exp_led};
      if (a == 16'd2049) return {15'b0, BUTTON};
      return 16'h0000;
   endfunction

   task automatic model_reset();
      exp_led      = 2'b00;
      exp_rdata[0] = 16'h0000;
      exp_rdata[1] = 16'h0000;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      REQ0 = 1'b0; WE0 = 1'b0; ADDR0 = '0; WDATA0 = '0;
      REQ1 = 1'b0; WE1 = 1'b0; ADDR1 = '0; WDATA1 = '0;
      repeat (2) begin @(posedge clk); #1; end
      RESET = 1'b0;
      model_reset();
   endtask

   task automatic set_button(input logic v);
      BUTTON = v;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   // One complete transaction on one port, started in an IDLE cycle.
   task automatic txn(input bit port, input bit we, input logic [15:0] addr,
                      input logic [15:0] wdata);
      int  lat;
      int  we_cnt;
      bit  we_bad;
      bit  other_ack;
      bit  is_ram;
      int  exp_lat;
      is_ram  = (addr < 16'd2048);
      exp_lat = (is_ram && !we) ? 3 : 2;
      if (port == 1'b0) begin
         REQ0 = 1'b1; WE0 = we; ADDR0 = addr; WDATA0 = wdata;
      end else begin
         REQ1 = 1'b1; WE1 = we; ADDR1 = addr; WDATA1 = wdata;
      end
      lat = 0; we_cnt = 0; we_bad = 1'b0; other_ack = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (RAM_WE) begin
            we_cnt++;
            if (n != 1 || RAM_ADDR !== addr[10:0] || RAM_WDATA !== wdata) we_bad = 1'b1;
         end
         if (port ? ACK0 : ACK1) other_ack = 1'b1;
         if (port ? ACK1 : ACK0) begin
            lat = n;
            break;
         end
      end
      // Reference model update.
      if (we) begin
         if (is_ram) shadow[addr[10:0]] = wdata;
         else if (addr == 16'd2048) exp_led = wdata[1:0];
      end else begin
         exp_rdata[port] = model_read(addr);
      end

      n_total++;
      if (lat !== exp_lat)
         $display("FAIL latency port%0d addr=%h we=%0d: got %0d want %0d", port, addr, we,
                  lat, exp_lat);
      else n_pass++;
      n_total++;
      if (we_cnt !== ((is_ram && we) ? 1 : 0) || we_bad)
         $display("FAIL ram_we addr=%h we=%0d: pulses=%0d bad=%0d want pulses=%0d", addr, we,
                  we_cnt, we_bad, (is_ram && we) ? 1 : 0);
      else n_pass++;
      n_total++;
      if (other_ack !== 1'b0)
         $display("FAIL wrong_port_ack port%0d: got 1 want 0", port);
      else n_pass++;
      n_total++;
      if (RDATA0 !== exp_rdata[0])
         $display("FAIL rdata0 addr=%h: got %h want %h", addr, RDATA0, exp_rdata[0]);
      else n_pass++;
      n_total++;
      if (RDATA1 !== exp_rdata[1])
         $display("FAIL rdata1 addr=%h: got %h want %h", addr, RDATA1, exp_rdata[1]);
      else n_pass++;
      n_total++;
      if (LED !== exp_led)
         $display("FAIL led addr=%h: got %b want %b", addr, LED, exp_led);
      else n_pass++;

      @(posedge clk); #1;
      if (port == 1'b0) REQ0 = 1'b0;
      else              REQ1 = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if ({ACK0, ACK1, RAM_WE} !== 3'b000)
         $display("FAIL reset_acks_we: got %b want 000", {ACK0, ACK1, RAM_WE});
      else n_pass++;
      n_total++;
      if (RDATA0 !== 16'h0 || RDATA1 !== 16'h0)
         $display("FAIL reset_rdata: got %h/%h want 0000/0000", RDATA0, RDATA1);
      else n_pass++;
      n_total++;
      if (RAM_ADDR !== 11'h0 || RAM_WDATA !== 16'h0)
         $display("FAIL reset_ram_bus: got %h/%h want 000/0000", RAM_ADDR, RAM_WDATA);
      else n_pass++;
      n_total++;
      if (LED !== 2'b00)
         $display("FAIL reset_led: got %b want 00", LED);
      else n_pass++;
   endtask

   task automatic test_basic();
      txn(1'b0, 1'b1, 16'd5, 16'h1234);
      txn(1'b0, 1'b0, 16'd5, 16'h0000);
      n_total++;
      if (RDATA0 !== 16'h1234)
         $display("FAIL basic_readback: got %h want 1234", RDATA0);
      else n_pass++;
   endtask

   task automatic test_mmio();
      txn(1'b0, 1'b1, 16'd2048, 16'h0003);
      txn(1'b1, 1'b0, 16'd2048, 16'h0000);
      set_button(1'b1);
      txn(1'b0, 1'b0, 16'd2049, 16'h0000);
      txn(1'b0, 1'b0, 16'h7FFF, 16'h0000);
      txn(1'b1, 1'b1, 16'h7FFF, 16'hFFFF);
      txn(1'b1, 1'b1, 16'd2049, 16'hFFFF);
      set_button(1'b0);
      txn(1'b1, 1'b0, 16'd2049, 16'h0000);
   endtask

   task automatic test_rdata_hold();
      logic [15:0] seen;
      txn(1'b0, 1'b0, 16'd9, 16'h0000);
      seen = exp_rdata[0];
      txn(1'b0, 1'b1, 16'd10, 16'hBEEF);
      n_total++;
      if (RDATA0 !== seen)
         $display("FAIL rdata_hold: got %h want %h", RDATA0, seen);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int unsigned kind;
         logic [15:0] a;
         kind = $urandom_range(0, 5);
         if (kind <= 2)      a = 16'($urandom_range(0, 15));
         else if (kind == 3) a = 16'd2048;
         else if (kind == 4) a = 16'd2049;
         else                a = 16'($urandom_range(2050, 65535));
         if ($urandom_range(0, 7) == 0) set_button(1'($urandom_range(0, 1)));
         txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
      end
   endtask

   task automatic test_round_robin();
      int k;
      bit order_bad;
      bit both;
      bit data_bad;
      do_reset();
      REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 16'd3;
      REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 16'd4;
      k = 0; order_bad = 1'b0; both = 1'b0; data_bad = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (ACK0 && ACK1) both = 1'b1;
         if (ACK0 || ACK1) begin
            if (ACK1 !== 1'((k % 2) == 1)) order_bad = 1'b1;
            if (ACK0 && RDATA0 !== shadow[3]) data_bad = 1'b1;
            if (ACK1 && RDATA1 !== shadow[4]) data_bad = 1'b1;
            k++;
         end
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      exp_rdata[0] = shadow[3];
      exp_rdata[1] = shadow[4];
      n_total++;
      if (k !== 10) $display("FAIL rr_grant_count: got %0d want 10", k);
      else n_pass++;
      n_total++;
      if (order_bad) $display("FAIL rr_order: got non-alternating want 0,1,0,1");
      else n_pass++;
      n_total++;
      if (both) $display("FAIL rr_ack_overlap: got ACK0&ACK1 want never");
      else n_pass++;
      n_total++;
      if (data_bad) $display("FAIL rr_rdata: got wrong read data want %h/%h", shadow[3], shadow[4]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int  first;
      int  lat;
      bit  stray;
      txn(1'b0, 1'b1, 16'd2048, 16'h0002);
      txn(1'b1, 1'b0, 16'd6, 16'h0000);
      REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 16'd7;
      @(posedge clk); #1;            // ISSUE
      @(posedge clk); #1;            // WAIT
      RESET = 1'b1;
      @(posedge clk); #1;
      RESET = 1'b0;
      REQ1 = 1'b0;
      model_reset();
      n_total++;
      if (ACK1 !== 1'b0 || LED !== 2'b00 || RDATA1 !== 16'h0)
         $display("FAIL midreset_state: got ack1=%b led=%b rdata1=%h want 0/00/0000", ACK1, LED,
                  RDATA1);
      else n_pass++;
      stray = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ACK0 || ACK1) stray = 1'b1;
      end
      n_total++;
      if (stray) $display("FAIL midreset_dropped_ack: got ack want none");
      else n_pass++;
      REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 16'd5;
      REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 16'd6;
      first = -1; lat = 0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (ACK0 || ACK1) begin
            first = ACK1 ? 1 : 0;
            lat = n;
            break;
         end
      end
      @(posedge clk); #1;
      REQ0 = 1'b0; REQ1 = 1'b0;
      exp_rdata[0] = shadow[5];
      n_total++;
      if (first !== 0 || lat !== 3)
         $display("FAIL midreset_tie: got port=%0d lat=%0d want port=0 lat=3", first, lat);
      else n_pass++;
      n_total++;
      if (RDATA0 !== exp_rdata[0])
         $display("FAIL midreset_rdata0: got %h want %h", RDATA0, exp_rdata[0]);
      else n_pass++;
      // Let the abandoned port-1 request drain if it was latched.
      repeat (6) begin @(posedge clk); #1; end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      BUTTON  = 1'b0;
      RESET   = 1'b1;
      REQ0 = 1'b0; WE0 = 1'b0; ADDR0 = '0; WDATA0 = '0;
      REQ1 = 1'b0; WE1 = 1'b0; ADDR1 = '0; WDATA1 = '0;
      for (int i = 0; i < 2048; i++) begin
         logic [15:0] v;
         v = 16'($urandom);
         ram_mem[i] = v;
         shadow[i]  = v;
      end
      model_reset();

      test_reset();
      test_basic();
      test_mmio();
      test_rdata_hold();
      test_random();
      test_round_robin();
      test_reset_mid();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
